alu8_seq: RTL and testbench

ALU8_SEQ -- requirements
Module: alu8_seq

---
 rtl/alu8_seq_if.sv | 30 +++
 rtl/alu8_seq.sv | 160 ++++++++++++++++
 tb/tb_alu8_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu8_seq_if.sv
// Bus between the 8-bit sequential ALU and its requester / external nibble ALU.
// The requester side (master) also plays the nibble ALU.
interface alu8_seq_if;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [3:0] flags;
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [2:0] nib_op;
    logic       nib_cin;
    logic [3:0] nib_out;
    logic       nib_z;
    logic       nib_c;

    modport master (
        output start, op, a, b, carry_in, nib_out, nib_z, nib_c,
        input  busy, done, result, flags, nib_a, nib_b, nib_op, nib_cin
    );

    modport slave (
        input  start, op, a, b, carry_in, nib_out, nib_z, nib_c,
        output busy, done, result, flags, nib_a, nib_b, nib_op, nib_cin
    );
endinterface

// File: rtl/alu8_seq.sv
// 8-bit ALU built from two passes through an external 4-bit nibble ALU.
// Flow: IDLE -> LO (low nibbles) -> HI (high nibbles) -> DONE (one-cycle pulse).
module alu8_seq (
    input  logic        clock,
    input  logic        reset,
    alu8_seq_if.slave   bus
);
    localparam int unsigned DW = 8;
    localparam int unsigned NW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_CP  = 3'd7;

    logic [1:0]    state, state_next;
    logic [DW-1:0] opa, opa_next, opb, opb_next;
    logic [2:0]    opc, opc_next;
    logic          cin_q, cin_next;
    logic [NW-1:0] lo_res, lo_res_next;
    logic          lo_z, lo_z_next, hc, hc_next;
    logic [DW-1:0] result_q, result_next;
    logic [3:0]    flags_q, flags_next;
    logic          busy_q, busy_next, done_q, done_next;
    logic [NW-1:0] nib_a_q, nib_a_next, nib_b_q, nib_b_next;
    logic [2:0]    nib_op_q, nib_op_next;
    logic          nib_cin_q, nib_cin_next;

    // Arithmetic ops and CP carry the half-carry chain; AND/XOR/OR do not.
    function automatic logic is_arith(input logic [2:0] o);
        return (o[2] == 1'b0) || (o == OP_CP);
    endfunction

    function automatic logic [2:0] hi_op(input logic [2:0] o);
        case (o)
            OP_ADD, OP_ADC: hi_op = OP_ADC;
            OP_SUB, OP_SBC: hi_op = OP_SBC;
            default:        hi_op = o;
        endcase
    endfunction

    // Next state, operand latching and result/flag assembly.
    always_comb begin
        state_next  = state;
        opa_next    = opa;
        opb_next    = opb;
        opc_next    = opc;
        cin_next    = cin_q;
        lo_res_next = lo_res;
        lo_z_next   = lo_z;
        hc_next     = hc;
        result_next = result_q;
        flags_next  = flags_q;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_LO;
                    opa_next   = bus.a;
                    opb_next   = bus.b;
                    opc_next   = bus.op;
                    cin_next   = bus.carry_in;
                end
            end
            S_LO: begin
                state_next  = S_HI;
                lo_res_next = bus.nib_out;
                lo_z_next   = bus.nib_z;
                hc_next     = bus.nib_c;
            end
            S_HI: begin
                state_next  = S_DONE;
                result_next = {bus.nib_out, lo_res};
                flags_next  = {lo_z & bus.nib_z,
                               (opc == OP_SUB) || (opc == OP_SBC) || (opc == OP_CP),
                               is_arith(opc) ? hc : (opc == OP_AND),
                               is_arith(opc) ? bus.nib_c : 1'b0};
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Nibble-ALU drives are registered, so they are derived from the next state.
    always_comb begin
        busy_next    = (state_next != S_IDLE);
        done_next    = (state_next == S_DONE);
        nib_a_next   = '0;
        nib_b_next   = '0;
        nib_op_next  = '0;
        nib_cin_next = 1'b0;
        case (state_next)
            S_LO: begin
                nib_a_next   = opa_next[3:0];
                nib_b_next   = opb_next[3:0];
                nib_op_next  = opc_next;
                nib_cin_next = ((opc_next == OP_ADC) || (opc_next == OP_SBC)) ? cin_next : 1'b0;
            end
            S_HI: begin
                nib_a_next   = opa_next[7:4];
                nib_b_next   = opb_next[7:4];
                nib_op_next  = hi_op(opc_next);
                nib_cin_next = is_arith(opc_next) ? hc_next : 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            opa       <= '0;
            opb       <= '0;
            opc       <= '0;
            cin_q     <= 1'b0;
            lo_res    <= '0;
            lo_z      <= 1'b0;
            hc        <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nib_a_q   <= '0;
            nib_b_q   <= '0;
            nib_op_q  <= '0;
            nib_cin_q <= 1'b0;
        end else begin
            state     <= state_next;
            opa       <= opa_next;
            opb       <= opb_next;
            opc       <= opc_next;
            cin_q     <= cin_next;
            lo_res    <= lo_res_next;
            lo_z      <= lo_z_next;
            hc        <= hc_next;
            result_q  <= result_next;
            flags_q   <= flags_next;
            busy_q    <= busy_next;
            done_q    <= done_next;
            nib_a_q   <= nib_a_next;
            nib_b_q   <= nib_b_next;
            nib_op_q  <= nib_op_next;
            nib_cin_q <= nib_cin_next;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.flags   = flags_q;
    assign bus.nib_a   = nib_a_q;
    assign bus.nib_b   = nib_b_q;
    assign bus.nib_op  = nib_op_q;
    assign bus.nib_cin = nib_cin_q;
endmodule

// File: tb/tb_alu8_seq.sv
// Testbench for alu8_seq: behavioural nibble ALU plus table-driven operations
// and hand-written sequences for start-ignore and mid-operation reset.
module tb_alu8_seq;
    logic clock = 1'b0;
    logic reset;

    alu8_seq_if bus();

    alu8_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural 4-bit nibble ALU.
    logic [4:0] nsum, ndiff;
    always_comb begin
        nsum  = 5'({1'b0, bus.nib_a}) + 5'({1'b0, bus.nib_b});
        ndiff = 5'({1'b0, bus.nib_a}) - 5'({1'b0, bus.nib_b});
        bus.nib_out = 4'h0;
        bus.nib_c   = 1'b0;
        case (bus.nib_op)
            3'd0: begin bus.nib_out = nsum[3:0]; bus.nib_c = nsum[4]; end
            3'd1: begin nsum = nsum + 5'(bus.nib_cin); bus.nib_out = nsum[3:0]; bus.nib_c = nsum[4]; end
            3'd2: begin bus.nib_out = ndiff[3:0]; bus.nib_c = ndiff[4]; end
            3'd3: begin ndiff = ndiff - 5'(bus.nib_cin); bus.nib_out = ndiff[3:0]; bus.nib_c = ndiff[4]; end
            3'd4: bus.nib_out = bus.nib_a & bus.nib_b;
            3'd5: bus.nib_out = bus.nib_a ^ bus.nib_b;
            3'd6: bus.nib_out = bus.nib_a | bus.nib_b;
            default: begin ndiff = ndiff - 5'(bus.nib_cin); bus.nib_out = bus.nib_a; bus.nib_c = ndiff[4]; end
        endcase
        bus.nib_z = (bus.nib_op == 3'd7) ? (ndiff[3:0] == 4'h0) : (bus.nib_out == 4'h0);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [3:0] flg;   // {Z,N,H,C}
        logic       hold;  // keep start high through LO/HI/DONE
    } vec_t;

    vec_t vecs[11];
    logic [7:0] prev_res;
    logic [3:0] prev_flg;

    function automatic logic [2:0] exp_hi_op(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: exp_hi_op = 3'd1;
            3'd2, 3'd3: exp_hi_op = 3'd3;
            default:    exp_hi_op = o;
        endcase
    endfunction

    task automatic run_op(input vec_t v);
        @(negedge clock);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b; bus.carry_in = v.cin;
        @(posedge clock); #1;
        // LO: operands must come from the latch, not the live inputs
        if (!v.hold) bus.start = 1'b0;
        bus.a = ~v.a; bus.b = ~v.b; bus.op = 3'd6; bus.carry_in = ~v.cin;
        check("lo_busy", 32'(bus.busy), 32'd1);
        check("lo_done", 32'(bus.done), 32'd0);
        check("lo_nib_a", 32'(bus.nib_a), 32'(v.a[3:0]));
        check("lo_nib_b", 32'(bus.nib_b), 32'(v.b[3:0]));
        check("lo_nib_op", 32'(bus.nib_op), 32'(v.op));
        check("lo_nib_cin", 32'(bus.nib_cin), 32'((v.op == 3'd1 || v.op == 3'd3) ? v.cin : 1'b0));
        check("lo_result_hold", 32'(bus.result), 32'(prev_res));
        @(posedge clock); #1;
        check("hi_done", 32'(bus.done), 32'd0);
        check("hi_nib_a", 32'(bus.nib_a), 32'(v.a[7:4]));
        check("hi_nib_b", 32'(bus.nib_b), 32'(v.b[7:4]));
        check("hi_nib_op", 32'(bus.nib_op), 32'(exp_hi_op(v.op)));
        check("hi_flags_hold", 32'(bus.flags), 32'(prev_flg));
        @(posedge clock); #1;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("result", 32'(bus.result), 32'(v.res));
        check("flags", 32'(bus.flags), 32'(v.flg));
        check("done_nib_idle", 32'({bus.nib_a, bus.nib_b, bus.nib_op, bus.nib_cin}), 32'd0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clock); #1;
        check("idle2_done", 32'(bus.done), 32'd0);
        check("idle2_busy", 32'(bus.busy), 32'd0);
        check("idle2_result", 32'(bus.result), 32'(v.res));
        prev_res = v.res;
        prev_flg = v.flg;
    endtask

    initial begin
        vecs[0]  = '{op: 3'd0, a: 8'h3A, b: 8'hC6, cin: 1'b0, res: 8'h00, flg: 4'b1011, hold: 1'b0};
        vecs[1]  = '{op: 3'd2, a: 8'h10, b: 8'h01, cin: 1'b0, res: 8'h0F, flg: 4'b0110, hold: 1'b0};
        vecs[2]  = '{op: 3'd7, a: 8'h42, b: 8'h42, cin: 1'b0, res: 8'h42, flg: 4'b1100, hold: 1'b0};
        vecs[3]  = '{op: 3'd7, a: 8'h10, b: 8'h20, cin: 1'b0, res: 8'h10, flg: 4'b0101, hold: 1'b0};
        vecs[4]  = '{op: 3'd1, a: 8'h0F, b: 8'h00, cin: 1'b1, res: 8'h10, flg: 4'b0010, hold: 1'b0};
        vecs[5]  = '{op: 3'd3, a: 8'h00, b: 8'h00, cin: 1'b1, res: 8'hFF, flg: 4'b0111, hold: 1'b0};
        vecs[6]  = '{op: 3'd4, a: 8'hF0, b: 8'h0F, cin: 1'b0, res: 8'h00, flg: 4'b1010, hold: 1'b1};
        vecs[7]  = '{op: 3'd6, a: 8'h0C, b: 8'h30, cin: 1'b0, res: 8'h3C, flg: 4'b0000, hold: 1'b0};
        vecs[8]  = '{op: 3'd5, a: 8'h5A, b: 8'h5A, cin: 1'b0, res: 8'h00, flg: 4'b1000, hold: 1'b1};
        vecs[9]  = '{op: 3'd0, a: 8'hFF, b: 8'h01, cin: 1'b0, res: 8'h00, flg: 4'b1011, hold: 1'b0};
        vecs[10] = '{op: 3'd0, a: 8'h01, b: 8'h01, cin: 1'b1, res: 8'h02, flg: 4'b0000, hold: 1'b0};

        bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00; bus.carry_in = 1'b0;
        reset = 1'b1;
        prev_res = 8'h00;
        prev_flg = 4'h0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_nib", 32'({bus.nib_a, bus.nib_b, bus.nib_op, bus.nib_cin}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) run_op(vecs[i]);

        // Reset during HI of ADD 0xFF+0x01 aborts with no done pulse.
        @(negedge clock);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 8'hFF; bus.b = 8'h01; bus.carry_in = 1'b0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("abort_in_hi", 32'(bus.nib_a), 32'hF);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'd0);
        check("abort_flags", 32'(bus.flags), 32'd0);
        check("abort_nib", 32'({bus.nib_a, bus.nib_b, bus.nib_op, bus.nib_cin}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("abort_no_done", 32'({bus.done, bus.busy}), 32'd0);
        end
        prev_res = 8'h00;
        prev_flg = 4'h0;
        run_op(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
